// File: rtl/regfile_arb_pkg.sv
// Shared constants and types for the register-file read arbiter.
// Optional hardwired-zero register is controlled by REGFILE_ZERO_REG_EN (see top).
package regfile_arb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd31;
endpackage

// File: rtl/regfile_read_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after ptr, wrapping modulo N.
// No configuration macros.
module rr_picker #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   grant_onehot,
   output logic [IDW-1:0] grant_idx,
   output logic           any
);
   int             j;
   logic [IDW-1:0] idx;

   always_comb begin
      grant_onehot = '0;
      grant_idx    = '0;
      any          = 1'b0;
      j            = 0;
      idx          = '0;
      // Scan offsets 1..N so the last winner is the lowest priority.
      for (int i = 1; i <= N; i++) begin
         j   = (int'(ptr) + i) % N;
         idx = IDW'(j);
         if (!any && req[idx]) begin
            any               = 1'b1;
            grant_idx         = idx;
            grant_onehot[idx] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 32:1 register-file read mux among NUM_REQ requesters.
// Define REGFILE_ZERO_REG_EN to make register 31 read as zero.
module regfile_read_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 64,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_REQ-1:0]                    req_valid,
   input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0]    req_addr,
   output logic [NUM_REQ-1:0]                    req_ready,
   output logic [REG_ADDR_W-1:0]                 mux_sel,
   input  logic [WIDTH-1:0]                      mux_data,
   output logic                                  rsp_valid,
   input  logic                                  rsp_ready,
   output logic [ID_W-1:0]                       rsp_id,
   output logic [WIDTH-1:0]                      rsp_data
);
   logic [NUM_REQ-1:0] gnt_oh;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic               s2_adv, s1_load;

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic               s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]    s1_id_q, s1_id_d;
   reg_addr_t          mux_sel_q, mux_sel_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;

   rr_picker #(.N(NUM_REQ), .IDW(ID_W)) u_pick (
      .req          (req_valid),
      .ptr          (ptr_q),
      .grant_onehot (gnt_oh),
      .grant_idx    (gnt_idx),
      .any          (gnt_any)
   );

   always_comb begin
      s2_adv      = !rsp_valid_q || rsp_ready;
      s1_load     = !s1_valid_q || s2_adv;
      req_ready   = (s1_load && reset_n) ? gnt_oh : '0;

      ptr_d       = ptr_q;
      s1_valid_d  = s1_valid_q;
      s1_id_d     = s1_id_q;
      mux_sel_d   = mux_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;

      if (s1_load) begin
         s1_valid_d = gnt_any;
         if (gnt_any) begin
            mux_sel_d = req_addr[gnt_idx];
            s1_id_d   = gnt_idx;
            ptr_d     = gnt_idx;
         end
      end

      // mux_data reflects mux_sel_q, i.e. the entry currently in stage 1.
      if (s2_adv) begin
         rsp_valid_d = s1_valid_q;
         rsp_id_d    = s1_id_q;
         rsp_data_d  = mux_data;
`ifdef REGFILE_ZERO_REG_EN
         if (mux_sel_q == ZERO_REG) rsp_data_d = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q       <= ID_W'(NUM_REQ-1);
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         mux_sel_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         mux_sel_q   <= mux_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign mux_sel   = mux_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Self-checking bench for regfile_read_arbiter (NUM_REQ=4, WIDTH=12) with a behavioural
// 32:1 read mux; honours REGFILE_ZERO_REG_EN when computing expected read data.
module tb_regfile_read_arbiter;
   localparam int NR = 4;
   localparam int W  = 12;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NR-1:0]         req_valid;
   logic [NR-1:0][4:0]    req_addr;
   logic [NR-1:0]         req_ready;
   logic [4:0]            mux_sel;
   logic [W-1:0]          mux_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [1:0]            rsp_id;
   logic [W-1:0]          rsp_data;

   logic [W-1:0] rf_mem [32];
   int n_pass = 0;
   int n_tot  = 0;

   typedef struct { int id; logic [W-1:0] data; } item_t;

   always #5 clk = ~clk;
   assign mux_data = rf_mem[mux_sel];

   regfile_read_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
      .req_ready(req_ready), .mux_sel(mux_sel), .mux_data(mux_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
   );

   function automatic logic [W-1:0] exp_data(input int addr);
`ifdef REGFILE_ZERO_REG_EN
      if (addr == 31) return '0;
`endif
      return rf_mem[addr];
   endfunction

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; req_valid = '0; req_addr = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
      @(negedge clk);
      n_tot++; if (req_ready !== 4'b0) $display("FAIL reset_ready got %b exp 0000", req_ready); else n_pass++;
      n_tot++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
      n_tot++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); else n_pass++;
      n_tot++; if (rsp_data !== 12'h0) $display("FAIL reset_rsp_data got %h exp 000", rsp_data); else n_pass++;
      n_tot++; if (mux_sel !== 5'd0) $display("FAIL reset_mux_sel got %0d exp 0", mux_sel); else n_pass++;
   endtask

   task automatic test_single();
      apply_reset();
      req_valid = 4'b0001; req_addr[0] = 5'd5; rsp_ready = 1'b1;
      @(negedge clk);
      n_tot++; if (req_ready !== 4'b0001) $display("FAIL single_ready got %b exp 0001", req_ready); else n_pass++;
      next_cycle(); req_valid = '0;
      @(negedge clk);
      n_tot++; if (rsp_valid !== 1'b0) $display("FAIL single_c1_valid got %b exp 0", rsp_valid); else n_pass++;
      n_tot++; if (mux_sel !== 5'd5) $display("FAIL single_mux_sel got %0d exp 5", mux_sel); else n_pass++;
      next_cycle();
      @(negedge clk);
      n_tot++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== rf_mem[5])
         $display("FAIL single_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=%h", rsp_valid, rsp_id, rsp_data, rf_mem[5]);
      else n_pass++;
   endtask

   task automatic test_all_four();
      logic [3:0] er;
      apply_reset();
      req_valid = 4'hF; rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) req_addr[i] = 5'(i + 1);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         er = 4'(1 << (c % 4));
         n_tot++; if (req_ready !== er) $display("FAIL all4_ready c%0d got %b exp %b", c, req_ready, er); else n_pass++;
         if (c >= 2) begin
            n_tot++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((c-2) % 4) || rsp_data !== rf_mem[(c-2) % 4 + 1])
               $display("FAIL all4_rsp c%0d got v=%b id=%0d d=%h exp id=%0d d=%h", c, rsp_valid, rsp_id,
                        rsp_data, (c-2) % 4, rf_mem[(c-2) % 4 + 1]);
            else n_pass++;
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      req_valid = 4'hF; rsp_ready = 1'b1;
      for (int i = 0; i < NR; i++) req_addr[i] = 5'(i + 1);
      repeat (3) next_cycle();
      rsp_ready = 1'b0;
      for (int c = 3; c < 6; c++) begin
         @(negedge clk);
         n_tot++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== rf_mem[2] || mux_sel !== 5'd3 || req_ready !== 4'b0)
            $display("FAIL bp_hold c%0d got v=%b id=%0d d=%h sel=%0d rdy=%b exp v=1 id=1 d=%h sel=3 rdy=0000",
                     c, rsp_valid, rsp_id, rsp_data, mux_sel, req_ready, rf_mem[2]);
         else n_pass++;
         next_cycle();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      n_tot++; if (req_ready !== 4'b1000 || rsp_id !== 2'd1)
         $display("FAIL bp_release got rdy=%b id=%0d exp rdy=1000 id=1", req_ready, rsp_id); else n_pass++;
      for (int k = 2; k <= 3; k++) begin
         next_cycle();
         @(negedge clk);
         n_tot++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(k) || rsp_data !== rf_mem[k+1])
            $display("FAIL bp_after id%0d got v=%b id=%0d d=%h exp d=%h", k, rsp_valid, rsp_id, rsp_data, rf_mem[k+1]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req_valid = 4'b0100; req_addr[2] = 5'd7; rsp_ready = 1'b1;
      @(negedge clk);
      n_tot++; if (req_ready !== 4'b0100) $display("FAIL rmid_ready got %b exp 0100", req_ready); else n_pass++;
      next_cycle(); req_valid = '0;
      #2 reset_n = 1'b0;
      #1;
      n_tot++; if (rsp_valid !== 1'b0 || mux_sel !== 5'd0)
         $display("FAIL rmid_async got v=%b sel=%0d exp v=0 sel=0", rsp_valid, mux_sel); else n_pass++;
      reset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tot++; if (rsp_valid !== 1'b0) $display("FAIL rmid_no_rsp c%0d got %b exp 0", c, rsp_valid); else n_pass++;
         next_cycle();
      end
      req_valid = 4'b1011;
      @(negedge clk);
      n_tot++; if (req_ready !== 4'b0001) $display("FAIL rmid_ptr got %b exp 0001", req_ready); else n_pass++;
      next_cycle(); req_valid = '0;
   endtask

   task automatic test_zero_reg();
      apply_reset();
      rf_mem[31] = 12'hCA8;
      req_valid = 4'b0010; req_addr[1] = 5'd31; rsp_ready = 1'b1;
      @(negedge clk);
      n_tot++; if (req_ready !== 4'b0010) $display("FAIL zreg_ready got %b exp 0010", req_ready); else n_pass++;
      next_cycle(); req_valid = '0;
      next_cycle();
      @(negedge clk);
      n_tot++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== exp_data(31))
         $display("FAIL zreg_rsp got v=%b id=%0d d=%h exp d=%h", rsp_valid, rsp_id, rsp_data, exp_data(31));
      else n_pass++;
   endtask

   // Transaction-level model: q holds accepted reads in order; head_out says q[0] is on the output.
   task automatic test_random();
      item_t      q[$];
      bit         head_out;
      int         m_ptr, g, pending, waitc[NR];
      bit         can_acc, pop;
      logic [3:0] exp_rdy;
      bit         vld[NR];
      logic [4:0] vaddr[NR];
      apply_reset();
      head_out = 0; m_ptr = NR - 1;
      for (int i = 0; i < NR; i++) begin vld[i] = 0; vaddr[i] = '0; waitc[i] = 0; end
      for (int cyc = 0; cyc < 1012; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            if (!vld[i] && cyc < 1000 && $urandom_range(0, 1) == 1) begin
               vld[i] = 1; vaddr[i] = 5'($urandom_range(0, 31));
            end
            req_valid[i] = vld[i];
            req_addr[i]  = vaddr[i];
         end
         rsp_ready = (cyc >= 1000) || ($urandom_range(0, 9) < 7);
         @(negedge clk);
         n_tot++; if (rsp_valid !== head_out) $display("FAIL rnd_valid cyc%0d got %b exp %b", cyc, rsp_valid, head_out); else n_pass++;
         if (head_out) begin
            n_tot++;
            if (rsp_id !== 2'(q[0].id) || rsp_data !== q[0].data)
               $display("FAIL rnd_rsp cyc%0d got id=%0d d=%h exp id=%0d d=%h", cyc, rsp_id, rsp_data, q[0].id, q[0].data);
            else n_pass++;
         end
         pending = q.size() - (head_out ? 1 : 0);
         can_acc = (pending == 0) || !head_out || rsp_ready;
         g = -1;
         for (int k = 1; k <= NR; k++)
            if (g < 0 && vld[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
         exp_rdy = (can_acc && g >= 0) ? 4'(1 << g) : 4'b0;
         n_tot++; if (req_ready !== exp_rdy) $display("FAIL rnd_ready cyc%0d got %b exp %b", cyc, req_ready, exp_rdy); else n_pass++;
         if (|req_ready) begin
            for (int i = 0; i < NR; i++) begin
               if (req_ready[i]) begin
                  n_tot++; if (waitc[i] >= NR) $display("FAIL rnd_starve req%0d waited %0d accepts exp <%0d", i, waitc[i], NR); else n_pass++;
                  waitc[i] = 0;
               end else if (vld[i]) waitc[i]++;
            end
         end
         pop = head_out && rsp_ready;
         if (pop) void'(q.pop_front());
         if (pop || !head_out) head_out = (pending > 0);
         if (exp_rdy != 4'b0) begin
            q.push_back('{g, exp_data(vaddr[g])});
            m_ptr = g; vld[g] = 0;
         end
         next_cycle();
      end
      req_valid = '0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = W'($urandom);
      rf_mem[31] = 12'hCA8;
      test_reset();
      test_single();
      test_all_four();
      test_backpressure();
      test_reset_mid();
      test_zero_reg();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout sim time exceeded bound");
      $fatal(1, "timeout");
   end
endmodule
